// File: rtl/video_delay_pkg.sv
// Shared helpers for the tapped video delay line: tap-select width and
// request clamping.
package video_delay_pkg;

  // Bits needed to encode every delay from 0 through max_dly inclusive.
  function automatic int dly_width(input int max_dly);
    return $clog2(max_dly + 1);
  endfunction

  function automatic int unsigned clamp_dly(input int unsigned sel,
                                            input int unsigned max_dly);
    if (sel > max_dly) begin
      return max_dly;
    end else begin
      return sel;
    end
  endfunction

endpackage

// File: rtl/tap_delay_line.sv
// Clock-enabled shift register of MAX_DLY stages with a runtime tap.
// A tap of 0 passes din straight through to dout.
module tap_delay_line
  import video_delay_pkg::*;
#(
  parameter int W       = 26,
  parameter int MAX_DLY = 8,
  localparam int DLY_W  = dly_width(MAX_DLY)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic [DLY_W-1:0] dly,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout
);

  logic [W-1:0] stage_q [1:MAX_DLY];

  // Clear has priority over the shift, so a stalled pipe still flushes.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 1; k <= MAX_DLY; k++) begin
        stage_q[k] <= '0;
      end
    end else if (ce) begin
      stage_q[1] <= din;
      for (int k = 2; k <= MAX_DLY; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end else begin
      for (int k = 1; k <= MAX_DLY; k++) begin
        stage_q[k] <= stage_q[k];
      end
    end
  end

  // The tap never exceeds MAX_DLY, so the bypass default is never left
  // standing for a nonzero tap.
  always_comb begin
    dout = din;
    if (dly == DLY_W'(0)) begin
      dout = din;
    end else begin
      for (int k = 1; k <= MAX_DLY; k++) begin
        if (dly == DLY_W'(k)) begin
          dout = stage_q[k];
        end else begin
          dout = dout;
        end
      end
    end
  end

endmodule

// File: rtl/video_tap_delay.sv
// Runtime-tapped delay for a {vsync, href, data} pixel bundle. Tap changes
// apply immediately or only at a vsync rising edge, and a fill flag
// reports whether the tap already holds samples taken since reset.
module video_tap_delay
  import video_delay_pkg::*;
#(
  parameter int DW            = 8,
  parameter int CH            = 3,
  parameter int MAX_DLY       = 8,
  parameter int DEFAULT_DLY   = 6,
  parameter int UPD_IMMEDIATE = 0,
  localparam int DLY_W        = dly_width(MAX_DLY)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [DLY_W-1:0]   dly_sel,
  input  logic               in_vsync,
  input  logic               in_href,
  input  logic [CH*DW-1:0]   in_data,
  output logic               out_vsync,
  output logic               out_href,
  output logic [CH*DW-1:0]   out_data,
  output logic               out_valid,
  output logic [DLY_W-1:0]   dly_cur,
  output logic               dly_chg
);

  localparam int BW = CH * DW + 2;

  logic [DLY_W-1:0] sel_c_s;
  logic             upd_s;
  logic [DLY_W-1:0] dly_q,     dly_d;
  logic [DLY_W-1:0] fill_q,    fill_d;
  logic             vs_prev_q, vs_prev_d;
  logic             dly_chg_q, dly_chg_d;
  logic [BW-1:0]    bus_in_s;
  logic [BW-1:0]    bus_out_s;

  assign sel_c_s  = DLY_W'(clamp_dly(32'(dly_sel), 32'(MAX_DLY)));
  assign bus_in_s = {in_vsync, in_href, in_data};

  // A change is taken only on an advancing cycle, and in frame mode only on
  // the cycle where vsync first goes high.
  always_comb begin
    upd_s = 1'b0;
    if (ce && (sel_c_s != dly_q)) begin
      if (UPD_IMMEDIATE != 0) begin
        upd_s = 1'b1;
      end else begin
        upd_s = in_vsync & ~vs_prev_q;
      end
    end else begin
      upd_s = 1'b0;
    end
  end

  always_comb begin
    dly_d     = dly_q;
    fill_d    = fill_q;
    vs_prev_d = vs_prev_q;
    dly_chg_d = upd_s;
    if (upd_s) begin
      dly_d = sel_c_s;
    end else begin
      dly_d = dly_q;
    end
    if (ce) begin
      vs_prev_d = in_vsync;
      if (fill_q != DLY_W'(MAX_DLY)) begin
        fill_d = fill_q + DLY_W'(1);
      end else begin
        fill_d = fill_q;
      end
    end else begin
      vs_prev_d = vs_prev_q;
      fill_d    = fill_q;
    end
  end

  // Control state register; reset overrides ce and any pending tap change.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q     <= DLY_W'(DEFAULT_DLY);
      fill_q    <= '0;
      vs_prev_q <= 1'b0;
      dly_chg_q <= 1'b0;
    end else begin
      dly_q     <= dly_d;
      fill_q    <= fill_d;
      vs_prev_q <= vs_prev_d;
      dly_chg_q <= dly_chg_d;
    end
  end

  tap_delay_line #(
    .W       (BW),
    .MAX_DLY (MAX_DLY)
  ) u_line (
    .clk  (clk),
    .clr  (rst),
    .ce   (ce),
    .dly  (dly_q),
    .din  (bus_in_s),
    .dout (bus_out_s)
  );

  assign {out_vsync, out_href, out_data} = bus_out_s;
  assign out_valid = (fill_q >= dly_q);
  assign dly_cur   = dly_q;
  assign dly_chg   = dly_chg_q;

endmodule

// File: tb/tb_video_tap_delay.sv
// Checks a frame-boundary and an immediate-update instance against a
// history-queue model, plus hand-computed points along the way.
module tb_video_tap_delay;

  localparam int DW = 8, CH = 3, MAX_DLY = 8, DEFAULT_DLY = 6;
  localparam int DLY_W = 4, BW = CH * DW + 2;

  logic clk = 1'b0, rst = 1'b1, ce = 1'b0, in_vsync = 1'b0, in_href = 1'b0;
  logic [CH*DW-1:0] in_data = '0;
  logic [DLY_W-1:0] sel_frm = 4'd6, sel_imm = 4'd6;

  logic f_vs, f_hr, f_valid, f_chg, i_vs, i_hr, i_valid, i_chg;
  logic [CH*DW-1:0] f_data, i_data;
  logic [DLY_W-1:0] f_cur, i_cur;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  logic [BW-1:0] hq[$];
  int fill, vsp;
  int mdly [2];
  int mchg [2];

  always #5 clk = ~clk;

  video_tap_delay #(.DW(DW), .CH(CH), .MAX_DLY(MAX_DLY), .DEFAULT_DLY(DEFAULT_DLY),
                    .UPD_IMMEDIATE(0)) u_frm (
    .clk(clk), .rst(rst), .ce(ce), .dly_sel(sel_frm), .in_vsync(in_vsync),
    .in_href(in_href), .in_data(in_data), .out_vsync(f_vs), .out_href(f_hr),
    .out_data(f_data), .out_valid(f_valid), .dly_cur(f_cur), .dly_chg(f_chg));

  video_tap_delay #(.DW(DW), .CH(CH), .MAX_DLY(MAX_DLY), .DEFAULT_DLY(DEFAULT_DLY),
                    .UPD_IMMEDIATE(1)) u_imm (
    .clk(clk), .rst(rst), .ce(ce), .dly_sel(sel_imm), .in_vsync(in_vsync),
    .in_href(in_href), .in_data(in_data), .out_vsync(i_vs), .out_href(i_hr),
    .out_data(i_data), .out_valid(i_valid), .dly_cur(i_cur), .dly_chg(i_chg));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: last MAX_DLY ce-samples, newest first; a tap of k reads entry k-1.
  task automatic cyc();
    int sc;
    @(posedge clk);
    if (rst) begin
      hq.delete();
      for (int k = 0; k < MAX_DLY; k++) hq.push_back('0);
      fill = 0;
      vsp  = 0;
      for (int m = 0; m < 2; m++) begin
        mdly[m] = DEFAULT_DLY;
        mchg[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        sc = (m == 0) ? int'(sel_frm) : int'(sel_imm);
        if (sc > MAX_DLY) sc = MAX_DLY;
        mchg[m] = (ce && sc != mdly[m] && (m == 1 || (in_vsync && vsp == 0))) ? 1 : 0;
        if (mchg[m] == 1) mdly[m] = sc;
      end
      if (ce) begin
        hq.push_front({in_vsync, in_href, in_data});
        void'(hq.pop_back());
        if (fill < MAX_DLY) fill++;
        vsp = in_vsync ? 1 : 0;
      end
    end
    #1;
  endtask

  function automatic logic [BW-1:0] exp_bus(input int m);
    if (mdly[m] == 0) return {in_vsync, in_href, in_data};
    return hq[mdly[m]-1];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("frm_bus",   32'({f_vs, f_hr, f_data}), 32'(exp_bus(0)));
      check("frm_valid", 32'(f_valid), 32'(fill >= mdly[0]));
      check("frm_cur",   32'(f_cur),   32'(mdly[0]));
      check("frm_chg",   32'(f_chg),   32'(mchg[0]));
      check("imm_bus",   32'({i_vs, i_hr, i_data}), 32'(exp_bus(1)));
      check("imm_valid", 32'(i_valid), 32'(fill >= mdly[1]));
      check("imm_cur",   32'(i_cur),   32'(mdly[1]));
      check("imm_chg",   32'(i_chg),   32'(mchg[1]));
    end
  end

  initial begin
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_data",  32'(f_data),  32'h0);
    check("rst_valid", 32'(f_valid), 32'h0);
    check("rst_cur",   32'(f_cur),   32'h6);

    // Ramp with continuous ce at the default tap of 6.
    in_href = 1'b1;
    ce = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_data = 24'(i);
      cyc();
      if (i == 5) check("ramp_valid5", 32'(f_valid), 32'h0);
      if (i == 6) begin
        check("ramp_valid6", 32'(f_valid), 32'h1);
        check("ramp_data6",  32'(f_data),  32'h1);
      end
      if (i == 9) check("ramp_data9", 32'(f_data), 32'h4);
    end

    // Alternating stall: only the ce=1 cycles advance.
    for (int j = 0; j < 8; j++) begin
      ce = (j % 2 == 0);
      in_data = 24'(100 + j);
      cyc();
    end
    check("stall_hold", 32'(f_data), 32'h8);

    // Frame-boundary update to 3.
    ce = 1'b1;
    sel_frm = 4'd3;
    for (int j = 0; j < 6; j++) begin
      in_vsync = (j >= 4);
      in_data = 24'(200 + j);
      cyc();
      if (j == 3) check("frm_wait_cur", 32'(f_cur), 32'h6);
      if (j == 4) begin
        check("frm_upd_cur",  32'(f_cur),  32'h3);
        check("frm_upd_chg",  32'(f_chg),  32'h1);
        check("frm_upd_data", 32'(f_data), 32'd202);
      end
      if (j == 5) begin
        check("frm_chg_end", 32'(f_chg),  32'h0);
        check("frm_data3",   32'(f_data), 32'd203);
      end
    end

    // Request 5 then revert to 3 before the next boundary: no change.
    sel_frm = 4'd5;
    cyc(); cyc();
    in_vsync = 1'b0;
    sel_frm = 4'd3;
    cyc(); cyc();
    in_vsync = 1'b1;
    cyc();
    check("revert_cur", 32'(f_cur), 32'h3);
    check("revert_chg", 32'(f_chg), 32'h0);
    sel_frm = 4'd6;
    in_vsync = 1'b0;
    cyc(); cyc();
    in_vsync = 1'b1;
    cyc();
    check("frm_back6", 32'(f_cur), 32'h6);
    in_vsync = 1'b0;

    // Immediate clamp, then bypass.
    sel_imm = 4'd15;
    cyc();
    check("imm_clamp", 32'(i_cur), 32'h8);
    sel_imm = 4'd0;
    in_data = 24'h5A5A5A;
    cyc();
    check("byp_cur",   32'(i_cur),   32'h0);
    check("byp_data",  32'(i_data),  32'h5A5A5A);
    check("byp_valid", 32'(i_valid), 32'h1);
    ce = 1'b0;
    in_data = 24'hC3C3C3;
    #1;
    check("byp_comb", 32'(i_data), 32'hC3C3C3);
    ce = 1'b1;
    cyc();

    // Reset during active href.
    in_href = 1'b1;
    sel_imm = 4'd2;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_href",  32'(f_hr),    32'h0);
    check("mrst_data",  32'(f_data),  32'h0);
    check("mrst_valid", 32'(f_valid), 32'h0);
    check("mrst_cur",   32'(f_cur),   32'h6);
    check("mrst_icur",  32'(i_cur),   32'h6);

    // Growth 2 -> 8 once four samples are in.
    for (int n = 1; n <= 8; n++) begin
      in_data = 24'(300 + n);
      if (n == 5) sel_imm = 4'd8;
      cyc();
      if (n == 4) begin
        check("grow_v4", 32'(i_valid), 32'h1);
        check("grow_c4", 32'(i_cur),   32'h2);
      end
      if (n == 5) begin
        check("grow_v5", 32'(i_valid), 32'h0);
        check("grow_c5", 32'(i_cur),   32'h8);
      end
      if (n == 7) check("grow_v7", 32'(i_valid), 32'h0);
      if (n == 8) begin
        check("grow_v8", 32'(i_valid), 32'h1);
        check("grow_d8", 32'(i_data),  32'd301);
      end
    end
    cyc(); cyc();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
